// File: rtl/m_chunk_adder_if.sv
// Operand/result handshake bundle for m_chunk_adder.
// The master side issues operands and accepts results; the adder is the slave.
interface m_chunk_adder_if #(
    parameter int D_N = 32
) ();
    logic           w_in_valid;
    logic           w_in_ready;
    logic [D_N-1:0] w_a;
    logic [D_N-1:0] w_b;
    logic           w_sub;
    logic           w_out_valid;
    logic           w_out_ready;
    logic [D_N-1:0] w_s;
    logic           w_cout;
    logic           w_ovf;

    modport master (
        output w_in_valid, w_a, w_b, w_sub, w_out_ready,
        input  w_in_ready, w_out_valid, w_s, w_cout, w_ovf
    );

    modport slave (
        input  w_in_valid, w_a, w_b, w_sub, w_out_ready,
        output w_in_ready, w_out_valid, w_s, w_cout, w_ovf
    );
endinterface

// File: rtl/m_chunk_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per cycle, carry held in a register
// between cycles. D_N must be a multiple of CHUNK.
//
// state | meaning
// IDLE  | ready for a new operation, last result held on w_s/w_cout/w_ovf
// BUSY  | adding one chunk per cycle, LSB chunk first
// DONE  | result valid, waiting for the consumer to take it
module m_chunk_adder #(
    parameter int D_N   = 32,
    parameter int CHUNK = 8
) (
    input logic            w_clk,
    input logic            w_rst,
    m_chunk_adder_if.slave bus
);
    localparam int NC = D_N / CHUNK;
    localparam int CW = (NC > 1) ? $clog2(NC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [D_N-1:0] a_q;
    logic [D_N-1:0] b_q;       // already inverted for subtract
    logic [D_N-1:0] acc_q;
    logic           carry_q;
    logic [CW-1:0]  cnt_q;
    logic [D_N-1:0] s_q;
    logic           cout_q;
    logic           ovf_q;

    logic           last_chunk;
    logic [31:0]    offset;
    logic [D_N-1:0] a_sh;
    logic [D_N-1:0] b_sh;
    logic [CHUNK:0] chunk_sum;
    logic [D_N-1:0] chunk_mask;
    logic [D_N-1:0] acc_next;
    logic           ovf_next;

    // Chunk adder and accumulator merge; the merged value already contains the
    // current chunk so the final edge can load the complete result.
    always_comb begin
        last_chunk = (cnt_q == CW'(NC - 1));
        offset     = 32'(cnt_q) * 32'(CHUNK);
        a_sh       = a_q >> offset;
        b_sh       = b_q >> offset;
        chunk_sum  = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};
        chunk_mask = D_N'({CHUNK{1'b1}}) << offset;
        acc_next   = (acc_q & ~chunk_mask)
                   | ((D_N'(chunk_sum[CHUNK-1:0]) << offset) & chunk_mask);
        ovf_next   = (a_q[D_N-1] == b_q[D_N-1]) && (acc_next[D_N-1] != a_q[D_N-1]);
    end

    // State register.
    always_ff @(posedge w_clk) begin
        if (w_rst) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.w_in_valid) state_next = BUSY;
            BUSY:    if (last_chunk) state_next = DONE;
            DONE:    if (bus.w_out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, per-chunk accumulation and result load.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.w_in_valid) begin
                        a_q     <= bus.w_a;
                        b_q     <= bus.w_sub ? ~bus.w_b : bus.w_b;
                        carry_q <= bus.w_sub;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                    end
                end
                BUSY: begin
                    acc_q   <= acc_next;
                    carry_q <= chunk_sum[CHUNK];
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_chunk) begin
                        s_q    <= acc_next;
                        cout_q <= chunk_sum[CHUNK];
                        ovf_q  <= ovf_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake flags follow the state directly; result fields come from registers.
    always_comb begin
        bus.w_in_ready  = (state == IDLE);
        bus.w_out_valid = (state == DONE);
        bus.w_s         = s_q;
        bus.w_cout      = cout_q;
        bus.w_ovf       = ovf_q;
    end
endmodule

// File: tb/tb_m_chunk_adder.sv
// Directed bench for m_chunk_adder: three instances (CHUNK = 8, 32, 1) share
// one stimulus stream so every vector is checked at all three latencies.
module tb_m_chunk_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        sub = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    m_chunk_adder_if #(.D_N(32)) bus8 ();
    m_chunk_adder_if #(.D_N(32)) bus32 ();
    m_chunk_adder_if #(.D_N(32)) bus1 ();

    assign bus8.w_in_valid   = in_valid;
    assign bus8.w_a          = a;
    assign bus8.w_b          = b;
    assign bus8.w_sub        = sub;
    assign bus8.w_out_ready  = out_ready;
    assign bus32.w_in_valid  = in_valid;
    assign bus32.w_a         = a;
    assign bus32.w_b         = b;
    assign bus32.w_sub       = sub;
    assign bus32.w_out_ready = out_ready;
    assign bus1.w_in_valid   = in_valid;
    assign bus1.w_a          = a;
    assign bus1.w_b          = b;
    assign bus1.w_sub        = sub;
    assign bus1.w_out_ready  = out_ready;

    m_chunk_adder #(.D_N(32), .CHUNK(8))  dut8  (.w_clk(clk), .w_rst(rst), .bus(bus8));
    m_chunk_adder #(.D_N(32), .CHUNK(32)) dut32 (.w_clk(clk), .w_rst(rst), .bus(bus32));
    m_chunk_adder #(.D_N(32), .CHUNK(1))  dut1  (.w_clk(clk), .w_rst(rst), .bus(bus1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called and returns at a negedge. Issues one operation to all three
    // instances, checks latency and result, optionally retires the result.
    task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                          input logic [31:0] es, input logic ec, input logic eo,
                          input bit retire, input string tag);
        int l8;
        int l32;
        int l1;
        l8  = -1;
        l32 = -1;
        l1  = -1;
        a = va;
        b = vb;
        sub = vs;
        in_valid = 1'b1;
        out_ready = 1'b0;
        check({tag, " in_ready"}, {29'd0, bus8.w_in_ready, bus32.w_in_ready, bus1.w_in_ready}, 32'd7);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int cyc = 0; cyc <= 40; cyc++) begin
            if (bus8.w_out_valid  && l8  < 0) l8  = cyc;
            if (bus32.w_out_valid && l32 < 0) l32 = cyc;
            if (bus1.w_out_valid  && l1  < 0) l1  = cyc;
            if (l8 >= 0 && l32 >= 0 && l1 >= 0) break;
            @(posedge clk);
            @(negedge clk);
        end
        check({tag, " lat c8"},  32'(l8),  32'd4);
        check({tag, " lat c32"}, 32'(l32), 32'd1);
        check({tag, " lat c1"},  32'(l1),  32'd32);
        check({tag, " s c8"},  bus8.w_s,  es);
        check({tag, " s c32"}, bus32.w_s, es);
        check({tag, " s c1"},  bus1.w_s,  es);
        check({tag, " cout/ovf c8"},  {30'd0, bus8.w_cout,  bus8.w_ovf},  {30'd0, ec, eo});
        check({tag, " cout/ovf c32"}, {30'd0, bus32.w_cout, bus32.w_ovf}, {30'd0, ec, eo});
        check({tag, " cout/ovf c1"},  {30'd0, bus1.w_cout,  bus1.w_ovf},  {30'd0, ec, eo});
        if (retire) begin
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            check({tag, " retire"}, {29'd0, bus8.w_out_valid, bus32.w_out_valid, bus1.w_out_valid}, 32'd0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset flags", {30'd0, bus8.w_out_valid, bus8.w_in_ready}, 32'd1);
        check("reset s", bus8.w_s, 32'd0);
        check("reset cout/ovf", {30'd0, bus8.w_cout, bus8.w_ovf}, 32'd0);
        rst = 1'b0;

        run_op(32'd45, 32'd34, 1'b0, 32'd79, 1'b0, 1'b0, 1'b1, "add 45+34");
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, "add ffffffff+1");
        run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, "add 7fffffff+1");
        run_op(32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, "sub 80000000-1");
        run_op(32'd34, 32'd45, 1'b1, 32'hFFFF_FFF5, 1'b0, 1'b0, 1'b1, "sub 34-45");
        run_op(32'd45, 32'd34, 1'b1, 32'd11, 1'b1, 1'b0, 1'b1, "sub 45-34");

        // Back-pressure: result must hold while new operands are offered.
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, "hold op");
        a = 32'hA000_0000;
        b = 32'hA000_0000;
        sub = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold s", bus8.w_s, 32'h2345_6789);
            check("hold flags", {30'd0, bus8.w_out_valid, bus8.w_in_ready}, 32'd2);
            check("hold c1 flags", {30'd0, bus1.w_out_valid, bus1.w_in_ready}, 32'd2);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("release flags", {30'd0, bus8.w_out_valid, bus8.w_in_ready}, 32'd1);
        run_op(32'hA000_0000, 32'hA000_0000, 1'b0, 32'h4000_0000, 1'b1, 1'b1, 1'b1, "after hold");

        // Reset in the second BUSY cycle abandons the operation.
        a = 32'd100;
        b = 32'd200;
        sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid reset flags", {30'd0, bus8.w_out_valid, bus8.w_in_ready}, 32'd1);
        check("mid reset s", bus8.w_s, 32'd0);
        check("mid reset cout/ovf", {30'd0, bus8.w_cout, bus8.w_ovf}, 32'd0);
        check("mid reset c1 s", bus1.w_s, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("no result after reset", {31'd0, bus8.w_out_valid}, 32'd0);
        end
        run_op(32'd100, 32'd200, 1'b0, 32'd300, 1'b0, 1'b0, 1'b1, "add 100+200");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
